// File: rtl/sme_matcher.sv
// KMP string matcher: steps one comparison per cycle over a preloaded string and
// pattern, using a caller-supplied failure function, and reports the leftmost match.
module sme_matcher #(
  parameter int BYTE        = 8,
  parameter int MAX_STRING  = 16,
  parameter int MAX_PATTERN = 8,
  parameter int MAX_STR_ADD = 4,
  parameter int MAX_PAT_ADD = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MAX_STRING*BYTE-1:0]         str_reg,
  input  logic [MAX_PATTERN*BYTE-1:0]        pat_reg,
  input  logic [MAX_STR_ADD-1:0]             str_last_idx,
  input  logic [MAX_PAT_ADD-1:0]             pat_last_idx,
  input  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_result,
  input  logic                               valid,
  output logic                               busy,
  output logic                               o_valid,
  output logic                               o_match,
  output logic [MAX_STR_ADD-1:0]             o_match_idx
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  state_t                 r_state;
  logic [MAX_STR_ADD-1:0] r_i;
  logic [MAX_PAT_ADD-1:0] r_q;
  logic                   r_valid_d;
  logic                   r_armed;
  logic                   r_busy;
  logic                   r_valid;
  logic                   r_match;
  logic [MAX_STR_ADD-1:0] r_match_idx;

  logic [BYTE-1:0]        w_str_bytes [MAX_STRING];
  logic [BYTE-1:0]        w_pat_bytes [MAX_PATTERN];
  logic [MAX_PAT_ADD-1:0] w_ff        [MAX_PATTERN];

  for (genvar gi = 0; gi < MAX_STRING; gi++) begin : g_str
    assign w_str_bytes[gi] = str_reg[gi*BYTE +: BYTE];
  end
  for (genvar gi = 0; gi < MAX_PATTERN; gi++) begin : g_pat
    assign w_pat_bytes[gi] = pat_reg[gi*BYTE +: BYTE];
    assign w_ff[gi]        = ff_result[gi*MAX_PAT_ADD +: MAX_PAT_ADD];
  end

  logic [MAX_STR_ADD-1:0] w_pat_last_ext;
  logic [MAX_PAT_ADD-1:0] w_q_prev;
  logic                   w_rise;
  logic                   w_eq;
  logic                   w_i_last;
  logic                   w_q_last;
  logic                   w_too_long;

  assign w_pat_last_ext = {{(MAX_STR_ADD-MAX_PAT_ADD){1'b0}}, pat_last_idx};
  assign w_q_prev       = r_q - 1'b1;
  // A level left high across reset never counts: valid must be seen low first.
  assign w_rise         = valid & ~r_valid_d & r_armed;
  assign w_eq           = (w_str_bytes[r_i] == w_pat_bytes[r_q]);
  assign w_i_last       = (r_i == str_last_idx);
  assign w_q_last       = (r_q == pat_last_idx);
  assign w_too_long     = (w_pat_last_ext > str_last_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_q         <= '0;
      r_valid_d   <= 1'b0;
      r_armed     <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_match     <= 1'b0;
      r_match_idx <= '0;
    end else begin
      r_valid_d <= valid;
      if (!valid) r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_i     <= '0;
            r_q     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (!valid) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_eq && w_q_last && !w_too_long) begin
            r_match     <= 1'b1;
            r_match_idx <= r_i - w_pat_last_ext;
            r_valid     <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end else if (w_too_long || (w_i_last && (w_eq || r_q == '0))) begin
            // Out of string: either the pattern cannot fit or the last byte was consumed.
            r_match     <= 1'b0;
            r_match_idx <= '0;
            r_valid     <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end else if (w_eq) begin
            r_q <= r_q + 1'b1;
            r_i <= r_i + 1'b1;
          end else if (r_q != '0) begin
            r_q <= w_ff[w_q_prev];
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        S_DONE: begin
          if (!valid) begin
            r_valid     <= 1'b0;
            r_match     <= 1'b0;
            r_match_idx <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign o_valid     = r_valid;
  assign o_match     = r_match;
  assign o_match_idx = r_match_idx;

endmodule

// File: tb/tb_sme_matcher.sv
// Directed and randomized bench for sme_matcher against a brute-force leftmost-match model.
module tb_sme_matcher;
  localparam int BYTE = 8, MS = 16, MP = 8, SA = 4, PA = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [MS*BYTE-1:0] str_reg = '0;
  logic [MP*BYTE-1:0] pat_reg = '0;
  logic [SA-1:0]     str_last_idx = '0;
  logic [PA-1:0]     pat_last_idx = '0;
  logic [PA*MP-1:0]  ff_result = '0;
  logic              valid = 1'b1;
  logic              busy, o_valid, o_match;
  logic [SA-1:0]     o_match_idx;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] str_m [MS];
  logic [7:0] pat_m [MP];
  int         ff_m  [MP];
  int         slen, plen;

  sme_matcher #(.BYTE(BYTE), .MAX_STRING(MS), .MAX_PATTERN(MP),
                .MAX_STR_ADD(SA), .MAX_PAT_ADD(PA)) dut (
    .clk(clk), .reset(reset), .str_reg(str_reg), .pat_reg(pat_reg),
    .str_last_idx(str_last_idx), .pat_last_idx(pat_last_idx),
    .ff_result(ff_result), .valid(valid), .busy(busy),
    .o_valid(o_valid), .o_match(o_match), .o_match_idx(o_match_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Builds border table by brute force and packs the model arrays onto the DUT inputs.
  task automatic apply_model();
    for (int k = 0; k < plen; k++) begin
      int best = 0;
      for (int b = 1; b <= k; b++) begin
        bit ok = 1'b1;
        for (int j = 0; j < b; j++)
          if (pat_m[j] != pat_m[k-b+1+j]) ok = 1'b0;
        if (ok) best = b;
      end
      ff_m[k] = best;
    end
    for (int k = plen; k < MP; k++) ff_m[k] = 0;
    for (int k = 0; k < MS; k++) str_reg[k*BYTE +: BYTE] = str_m[k];
    for (int k = 0; k < MP; k++) begin
      pat_reg[k*BYTE +: BYTE] = pat_m[k];
      ff_result[k*PA +: PA]   = PA'(ff_m[k]);
    end
    str_last_idx = SA'(slen - 1);
    pat_last_idx = PA'(plen - 1);
  endtask

  task automatic load(input string s, input string p);
    slen = s.len();
    plen = p.len();
    for (int k = 0; k < MS; k++) str_m[k] = (k < slen) ? s[k] : 8'($urandom);
    for (int k = 0; k < MP; k++) pat_m[k] = (k < plen) ? p[k] : 8'($urandom);
    apply_model();
  endtask

  function automatic int find_first();
    for (int st = 0; st + plen <= slen; st++) begin
      bit ok = 1'b1;
      for (int j = 0; j < plen; j++)
        if (str_m[st+j] != pat_m[j]) ok = 1'b0;
      if (ok) return st;
    end
    return -1;
  endfunction

  task automatic run_case(input string tag);
    int exp_idx, lat, bound;
    exp_idx = find_first();
    bound   = 2 * slen + 1;
    valid = 1'b0;
    @(posedge clk); #1;
    valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    chk({tag, ":busy_start"}, 32'(busy), 1);
    while (!o_valid && lat < bound) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ":o_valid_seen"}, 32'(o_valid), 1);
    if (plen > slen) chk({tag, ":short_latency"}, 32'(lat), 2);
    chk({tag, ":o_match"}, 32'(o_match), (exp_idx >= 0) ? 1 : 0);
    chk({tag, ":o_match_idx"}, 32'(o_match_idx), (exp_idx >= 0) ? 32'(exp_idx) : 0);
    chk({tag, ":busy_done"}, 32'(busy), 0);
    $display("case %s slen=%0d plen=%0d lat=%0d match=%0b idx=%0d exp_idx=%0d",
             tag, slen, plen, lat, o_match, o_match_idx, exp_idx);
    @(posedge clk); #1;
    chk({tag, ":o_valid_hold"}, 32'(o_valid), 1);
    valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, ":o_valid_clr"}, 32'(o_valid), 0);
    chk({tag, ":o_match_clr"}, 32'({o_match, o_match_idx}), 0);
  endtask

  initial begin
    // Reset with valid already high; a search must not start on release.
    #2;
    chk("rst:outputs", 32'({busy, o_valid, o_match, o_match_idx}), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
    end
    chk("rst:no_start", 32'({busy, o_valid}), 0);

    load("abcabd", "abd");   run_case("abcabd");
    chk("abcabd:ff2", 32'(ff_m[2]), 0);
    load("aaab", "aab");     run_case("aaab");
    chk("aaab:ff1", 32'(ff_m[1]), 1);
    load("abc", "d");        run_case("abc_d");
    load("abc", "abcab");    run_case("too_long");

    for (int r = 0; r < 25; r++) begin
      slen = $urandom_range(1, MS);
      plen = ($urandom_range(0, 4) == 0) ? $urandom_range(1, MP)
                                         : $urandom_range(1, (slen < MP) ? slen : MP);
      for (int k = 0; k < MP; k++) pat_m[k] = 8'h61 + 8'($urandom_range(0, 1));
      for (int k = 0; k < MS; k++)
        str_m[k] = (k < slen) ? 8'h61 + 8'($urandom_range(0, 2) == 2 ? 2 : $urandom_range(0, 1))
                              : 8'($urandom);
      if (plen <= slen && $urandom_range(0, 1) == 1) begin
        int pos = $urandom_range(0, slen - plen);
        for (int j = 0; j < plen; j++) str_m[pos+j] = pat_m[j];
      end
      apply_model();
      run_case($sformatf("rand%0d", r));
    end

    // Abort: valid drops during a long search.
    load("aaaaaaaaaaaaaaaa", "ab");
    valid = 1'b0;
    @(posedge clk); #1;
    valid = 1'b1;
    @(posedge clk); #1;
    chk("abort:busy_start", 32'(busy), 1);
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    chk("abort:busy_clr", 32'(busy), 0);
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (o_valid) seen = 1'b1;
      end
      chk("abort:no_o_valid", 32'(seen), 0);
    end
    $display("case abort busy=%0b o_valid=%0b", busy, o_valid);

    // Reset mid-search, valid held high afterwards.
    load("aaaaaaaaaaaaaaab", "ab");
    valid = 1'b1;
    @(posedge clk); #1;
    chk("rstmid:busy_start", 32'(busy), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rstmid:outputs", 32'({busy, o_valid, o_match, o_match_idx}), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (o_valid || busy) seen = 1'b1;
      end
      chk("rstmid:no_result", 32'(seen), 0);
    end
    $display("case reset_mid busy=%0b o_valid=%0b", busy, o_valid);
    run_case("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
